// File: rtl/ex_mem_pipe_reg_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_reg_pkg
// Shared types and constants for the EX->MEM pipeline register.
//   ex_mem_ctrl_t : packed bundle of the control bits carried EX->MEM
//   BR_EQ / BR_NE : encodings of the br_ne input (branch on zero / not zero)
// ---------------------------------------------------------------------------
package ex_mem_pipe_reg_pkg;

   typedef struct packed {
      logic memtoreg;
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic jump;
      logic halt;
      logic word_en;
      logic ld_en;
   } ex_mem_ctrl_t;

   localparam logic BR_EQ = 1'b0;
   localparam logic BR_NE = 1'b1;

endpackage : ex_mem_pipe_reg_pkg

// File: rtl/ex_mem_pipe_reg_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   rst   : synchronous reset, active-high, clears count
//   inc   : add one this edge (ignored once saturated)
//   count : current value, CNT_W bits
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // NOTE: state is written with non-blocking assignments so every register
   // samples its inputs from before the edge, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule : sat_counter

// File: rtl/ex_mem_pipe_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_reg
// EX->MEM pipeline register with valid bit, stall/flush, BEQ/BNE branch
// resolution, sticky halt and a saturating taken-branch counter.
// Edge priority: rst > flush > (stall | halted) > load.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall, flush             hold the stage / insert a bubble
//   in_valid                 EX entry is a real instruction
//   memtoreg .. ld_en        control bits, registered as <ctrl>_reg
//   branch, br_ne, zero      branch resolution inputs -> pcsrc
//   pc_branch, alu_out,
//   reg_out, instr_rd        datapath, registered as <name>_reg
//   valid_reg                MEM entry valid
//   pcsrc                    registered branch-taken (level while held)
//   halted                   sticky, set when a valid halt reaches MEM
//   br_taken_cnt             saturating count of taken branches
// ---------------------------------------------------------------------------
module ex_mem_pipe_reg
   import ex_mem_pipe_reg_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int PC_W   = 16,
   parameter int RD_W   = 3,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              memtoreg,
   input  logic              reg_write,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              branch,
   input  logic              br_ne,
   input  logic              zero,
   input  logic              jump,
   input  logic              halt,
   input  logic              word_en,
   input  logic              ld_en,
   input  logic [PC_W-1:0]   pc_branch,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [DATA_W-1:0] reg_out,
   input  logic [RD_W-1:0]   instr_rd,
   output logic              valid_reg,
   output logic              memtoreg_reg,
   output logic              reg_write_reg,
   output logic              mem_read_reg,
   output logic              mem_write_reg,
   output logic              jump_reg,
   output logic              halt_reg,
   output logic              word_en_reg,
   output logic              ld_en_reg,
   output logic              pcsrc,
   output logic [PC_W-1:0]   pc_branch_reg,
   output logic [DATA_W-1:0] alu_out_reg,
   output logic [DATA_W-1:0] reg_out_reg,
   output logic [RD_W-1:0]   instr_rd_reg,
   output logic              halted,
   output logic [CNT_W-1:0]  br_taken_cnt
);

   ex_mem_ctrl_t ctrl_in;
   ex_mem_ctrl_t ctrl_q;
   logic         hold;
   logic         load;
   logic         cond_met;
   logic         pcsrc_d;

   assign ctrl_in = '{memtoreg:  memtoreg,
                      reg_write: reg_write,
                      mem_read:  mem_read,
                      mem_write: mem_write,
                      jump:      jump,
                      halt:      halt,
                      word_en:   word_en,
                      ld_en:     ld_en};

   // A reached halt freezes the stage exactly like an external stall.
   assign hold     = stall | halted;
   assign load     = ~flush & ~hold;
   assign cond_met = (br_ne == BR_EQ) ? zero : ~zero;
   assign pcsrc_d  = in_valid & branch & cond_met;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg     <= 1'b0;
         ctrl_q        <= '0;
         pcsrc         <= 1'b0;
         halted        <= 1'b0;
         pc_branch_reg <= '0;
         alu_out_reg   <= '0;
         reg_out_reg   <= '0;
         instr_rd_reg  <= '0;
      end else if (flush) begin
         // NOTE: a bubble only needs its valid/control bits cleared; the
         // datapath registers keep their old contents since nothing downstream
         // acts on them while valid_reg=0. halted is deliberately untouched.
         valid_reg <= 1'b0;
         ctrl_q    <= '0;
         pcsrc     <= 1'b0;
      end else if (!hold) begin
         valid_reg     <= in_valid;
         // Gate every control with in_valid so a dead entry never writes
         // memory or the register file.
         ctrl_q        <= ctrl_in & {$bits(ex_mem_ctrl_t){in_valid}};
         pcsrc         <= pcsrc_d;
         pc_branch_reg <= pc_branch;
         alu_out_reg   <= alu_out;
         reg_out_reg   <= reg_out;
         instr_rd_reg  <= instr_rd;
         if (in_valid && halt) begin
            halted <= 1'b1;
         end
      end
   end

   assign memtoreg_reg  = ctrl_q.memtoreg;
   assign reg_write_reg = ctrl_q.reg_write;
   assign mem_read_reg  = ctrl_q.mem_read;
   assign mem_write_reg = ctrl_q.mem_write;
   assign jump_reg      = ctrl_q.jump;
   assign halt_reg      = ctrl_q.halt;
   assign word_en_reg   = ctrl_q.word_en;
   assign ld_en_reg     = ctrl_q.ld_en;

   // Counts on the same edge that loads a new pcsrc=1.
   sat_counter #(
      .CNT_W (CNT_W)
   ) u_br_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (load & pcsrc_d),
      .count (br_taken_cnt)
   );

endmodule : ex_mem_pipe_reg
